// File: rtl/uart_transmitter.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding a start/8 data/even parity/stop
// serialiser, with a forced idle-high gap after every frame.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 din,
  input  logic                       wr_en,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW       = $clog2(DEPTH + 1);
  localparam int AW       = $clog2(DEPTH);
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int TW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_par;
  logic [2:0]      r_idx;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_limit;
  logic            w_bit_end;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            r_tx;
  logic            w_tx_nxt;
  logic            r_frame_done;
  logic            w_frame_done_nxt;
  logic            w_busy;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = wr_en && !w_full;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
  // The gap phase reuses the bit timer with a longer terminal count.
  assign w_limit   = (r_state == S_GAP) ? TW'(GAP_CLKS - 1) : TW'(CLKS_PER_BIT - 1);
  assign w_bit_end = (r_timer == w_limit);

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_overflow <= wr_en && w_full;
    end
  end

  // State register plus bit timing/index control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= (w_bit_end || r_state == S_IDLE) ? '0 : r_timer + 1'b1;
      if (r_state == S_START)
        r_idx <= '0;
      else if (r_state == S_DATA && w_bit_end && r_idx != 3'd7)
        r_idx <= r_idx + 1'b1;
      r_tx         <= w_tx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
    if (w_pop) r_par <= ^r_mem[r_rptr];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pop)                         w_state_nxt = S_START;
      S_START:  if (w_bit_end)                     w_state_nxt = S_DATA;
      S_DATA:   if (w_bit_end && r_idx == 3'd7)    w_state_nxt = S_PARITY;
      S_PARITY: if (w_bit_end)                     w_state_nxt = S_STOP;
      S_STOP:   if (w_bit_end)                     w_state_nxt = S_GAP;
      S_GAP:    if (w_bit_end)                     w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes exactly on the bit edge.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop)
      w_shift_nxt = r_mem[r_rptr];
    else if (r_state == S_DATA && w_bit_end)
      w_shift_nxt = {1'b0, r_shift[7:1]};
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_frame_done_nxt = (r_state == S_STOP) && w_bit_end;
    w_busy           = (r_state != S_IDLE);
  end

  assign full       = w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign tx         = r_tx;
  assign busy       = w_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a CPB=1 and a CPB=4 instance, a serial-line monitor that
// decodes frames into a queue, and scoreboarded expected bytes.
module tb_uart_transmitter;

  logic       clk;
  logic       rst1_n, rst4_n;
  logic [7:0] din;
  logic       wr1, wr4;
  logic       full1, ovf1, tx1, busy1, fd1;
  logic       full4, ovf4, tx4, busy4, fd4;
  logic [2:0] count1, count4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         start_cyc;
  } frame_t;

  frame_t     rx_q [$];
  logic [7:0] exp_q [$];

  uart_transmitter #(.CLKS_PER_BIT(1), .GAP_BITS(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .din(din), .wr_en(wr1), .full(full1), .count(count1),
    .overflow(ovf1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .GAP_BITS(1), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .din(din), .wr_en(wr4), .full(full4), .count(count4),
    .overflow(ovf4), .tx(tx4), .busy(busy4), .frame_done(fd4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor for the CPB=1 instance; frames cut by reset are discarded.
  frame_t     m_f;
  logic [9:0] m_bits;
  logic       m_ab;
  always begin
    @(negedge clk);
    if (rst1_n === 1'b1 && tx1 === 1'b0) begin
      m_ab = 1'b0;
      m_f.start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rst1_n !== 1'b1) m_ab = 1'b1;
        m_bits[i] = tx1;
      end
      if (!m_ab) begin
        m_f.data = m_bits[7:0];
        m_f.par  = m_bits[8];
        m_f.stop = m_bits[9];
        rx_q.push_back(m_f);
      end
    end
  end

  task automatic test_reset();
    rst1_n = 1'b0; rst4_n = 1'b0; wr1 = 1'b0; wr4 = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (tx1 !== 1'b1)     begin n_fail++; $display("FAIL reset_tx1 got %b want 1", tx1); end
    n_checks++; if (busy1 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    n_checks++; if (full1 !== 1'b0)   begin n_fail++; $display("FAIL reset_full1 got %b want 0", full1); end
    n_checks++; if (count1 !== 3'd0)  begin n_fail++; $display("FAIL reset_count1 got %0d want 0", count1); end
    n_checks++; if (ovf1 !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf1 got %b want 0", ovf1); end
    n_checks++; if (fd1 !== 1'b0)     begin n_fail++; $display("FAIL reset_fd1 got %b want 0", fd1); end
    n_checks++; if (tx4 !== 1'b1)     begin n_fail++; $display("FAIL reset_tx4 got %b want 1", tx4); end
    n_checks++; if (busy4 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    n_checks++; if (count4 !== 3'd0)  begin n_fail++; $display("FAIL reset_count4 got %0d want 0", count4); end
    n_checks++; if (fd4 !== 1'b0)     begin n_fail++; $display("FAIL reset_fd4 got %b want 0", fd4); end
    rst1_n = 1'b1; rst4_n = 1'b1;
  endtask

  // One byte from idle: cycle-exact tx/busy/frame_done waveform, then scoreboard check.
  task automatic test_frame(input int cpb, input logic [7:0] b);
    frame_t     f;
    logic [7:0] e;
    logic       txv, bsv, fdv, etx;
    logic [2:0] cnt;
    int         idx;
    repeat (4) @(negedge clk);
    rx_q.delete();
    din = b;
    if (cpb == 1) begin wr1 = 1'b1; exp_q.push_back(b); end
    else wr4 = 1'b1;
    for (int k = 0; k <= 12 * cpb + 2; k++) begin
      @(negedge clk);
      wr1 = 1'b0; wr4 = 1'b0;
      txv = (cpb == 1) ? tx1 : tx4;
      bsv = (cpb == 1) ? busy1 : busy4;
      fdv = (cpb == 1) ? fd1 : fd4;
      cnt = (cpb == 1) ? count1 : count4;
      if (k < 1 || k > 11 * cpb) etx = 1'b1;
      else begin
        idx = (k - 1) / cpb;
        if (idx == 0)      etx = 1'b0;
        else if (idx <= 8) etx = b[idx-1];
        else if (idx == 9) etx = ^b;
        else               etx = 1'b1;
      end
      if (k == 0) begin
        n_checks++;
        if (cnt !== 3'd1) begin n_fail++; $display("FAIL frame_count cpb=%0d got %0d want 1", cpb, cnt); end
      end
      n_checks++;
      if (txv !== etx) begin n_fail++; $display("FAIL frame_tx cpb=%0d k=%0d got %b want %b", cpb, k, txv, etx); end
      n_checks++;
      if (bsv !== (k >= 1 && k <= 12 * cpb)) begin
        n_fail++; $display("FAIL frame_busy cpb=%0d k=%0d got %b want %b", cpb, k, bsv, (k >= 1 && k <= 12 * cpb));
      end
      n_checks++;
      if (fdv !== (k == 11 * cpb + 1)) begin
        n_fail++; $display("FAIL frame_done cpb=%0d k=%0d got %b want %b", cpb, k, fdv, (k == 11 * cpb + 1));
      end
    end
    if (cpb == 1) begin
      n_checks++;
      if (rx_q.size() != 1 || exp_q.size() != 1) begin
        n_fail++; $display("FAIL frame_rxcount got %0d want 1", rx_q.size());
        rx_q.delete(); exp_q.delete();
      end else begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if ({f.data, f.par, f.stop} !== {e, ^e, 1'b1}) begin
          n_fail++; $display("FAIL frame_rx got %h/%b/%b want %h/%b/1", f.data, f.par, f.stop, e, ^e);
        end
      end
    end
  endtask

  // Fill the FIFO while a frame is in flight, overflow once, then drain in order.
  task automatic test_fifo_fill();
    frame_t     f;
    logic [7:0] e;
    logic [7:0] vals [6];
    int         prev;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    repeat (4) @(negedge clk);
    rx_q.delete();
    din = vals[0]; wr1 = 1'b1; exp_q.push_back(vals[0]);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j == 1) begin
        n_checks++;
        if (count1 !== 3'd1) begin n_fail++; $display("FAIL fill_count_j1 got %0d want 1", count1); end
      end
      if (j == 4) begin
        n_checks++;
        if (full1 !== 1'b1 || count1 !== 3'd4) begin
          n_fail++; $display("FAIL fill_full got full=%b count=%0d want full=1 count=4", full1, count1);
        end
      end
      if (j == 5) begin
        n_checks++;
        if (ovf1 !== 1'b1 || count1 !== 3'd4) begin
          n_fail++; $display("FAIL fill_overflow got ovf=%b count=%0d want ovf=1 count=4", ovf1, count1);
        end
      end
      if (j == 6) begin
        n_checks++;
        if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse got %b want 0", ovf1); end
      end
      if (j < 5) begin
        din = vals[j+1];
        if (j < 4) exp_q.push_back(vals[j+1]);
      end else wr1 = 1'b0;
    end
    for (int t = 0; t < 200 && rx_q.size() < 5; t++) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 5) begin
      n_fail++; $display("FAIL fill_rxcount got %0d want 5", rx_q.size());
    end
    prev = -1;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({f.data, f.par, f.stop} !== {e, ^e, 1'b1}) begin
        n_fail++; $display("FAIL fill_rx got %h/%b/%b want %h/%b/1", f.data, f.par, f.stop, e, ^e);
      end
      if (prev >= 0) begin
        n_checks++;
        if (f.start_cyc - prev != 13) begin
          n_fail++; $display("FAIL fill_spacing got %0d want 13", f.start_cyc - prev);
        end
      end
      prev = f.start_cyc;
    end
    rx_q.delete(); exp_q.delete();
  endtask

  // Write lands on the same edge as the pop of a single queued byte; frames run back to back.
  task automatic test_back_to_back();
    frame_t f0, f1;
    repeat (4) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    din = 8'h5A; wr1 = 1'b1; exp_q.push_back(8'h5A);
    @(negedge clk);
    din = 8'hC3; exp_q.push_back(8'hC3);
    @(negedge clk);
    wr1 = 1'b0;
    n_checks++;
    if (count1 !== 3'd1) begin n_fail++; $display("FAIL b2b_count got %0d want 1", count1); end
    for (int t = 0; t < 100 && rx_q.size() < 2; t++) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_rxcount got %0d want 2", rx_q.size());
    end else begin
      f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
      n_checks++;
      if (f0.data !== exp_q[0] || f1.data !== exp_q[1]) begin
        n_fail++; $display("FAIL b2b_data got %h %h want %h %h", f0.data, f1.data, exp_q[0], exp_q[1]);
      end
      // 11 frame clocks + 2 idle-high clocks between stop and the next start
      n_checks++;
      if (f1.start_cyc - f0.start_cyc != 13) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want 13", f1.start_cyc - f0.start_cyc);
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    repeat (4) @(negedge clk);
    din = 8'hF0; wr1 = 1'b1;
    @(negedge clk);
    din = 8'h0F;
    @(negedge clk);
    wr1 = 1'b0;
    repeat (4) @(negedge clk);
    rst1_n = 1'b0;
    #1;
    n_checks++; if (tx1 !== 1'b1)    begin n_fail++; $display("FAIL rstmid_tx got %b want 1", tx1); end
    n_checks++; if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy1); end
    n_checks++; if (count1 !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", count1); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
    test_frame(1, 8'h3C);
  endtask

  initial begin
    test_reset();
    test_frame(1, 8'hA5);
    test_frame(1, 8'h01);
    test_fifo_fill();
    test_back_to_back();
    test_frame(4, 8'hA5);
    test_frame(4, 8'h01);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
